vram_tile_write_scheduler: RTL and testbench

//  Owns the write port of vram_tile_memory (15-bit pixel-pair address, 16-bit data).

---
 rtl/vram_tile_write_scheduler_if.sv | 42 ++++
 rtl/vram_tile_write_scheduler.sv | 144 ++++++++++++++
 tb/tb_vram_tile_write_scheduler.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_tile_write_scheduler_if.sv
// Bus bundle between the MCU decoder / fill requester, the write scheduler and
// the write port of vram_tile_memory.
interface vram_tile_write_scheduler_if #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 16
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic              cpu_wr_valid;
    logic              cpu_wr_ready;
    logic [ADDR_W-1:0] cpu_wr_addr;
    logic [DATA_W-1:0] cpu_wr_data;
    logic              fill_start;
    logic [ADDR_W-1:0] fill_base;
    logic [ADDR_W:0]   fill_count;
    logic [DATA_W-1:0] fill_data;
    logic              fill_ready;
    logic              fill_busy;
    logic              gate_en;
    logic              blank;
    logic [LVL_W-1:0]  fifo_level;
    logic              write_enable;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;

    modport master (
        output cpu_wr_valid, cpu_wr_addr, cpu_wr_data,
        output fill_start, fill_base, fill_count, fill_data,
        output gate_en, blank,
        input  cpu_wr_ready, fill_ready, fill_busy, fifo_level,
        input  write_enable, write_addr, write_data
    );

    modport slave (
        input  cpu_wr_valid, cpu_wr_addr, cpu_wr_data,
        input  fill_start, fill_base, fill_count, fill_data,
        input  gate_en, blank,
        output cpu_wr_ready, fill_ready, fill_busy, fifo_level,
        output write_enable, write_addr, write_data
    );
endinterface

// File: rtl/vram_tile_write_scheduler.sv
// Owns the vram_tile_memory write port: queues MCU pixel-pair writes in a FIFO and
// runs a bulk fill engine, committing one write per cycle only inside the write window.
module vram_tile_write_scheduler #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 16
) (
    input logic                        clk,
    input logic                        reset,
    vram_tile_write_scheduler_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, DRAIN, FILL} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fifo_addr_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
    logic [ADDR_W:0]   fill_rem_q, fill_rem_d;
    logic [DATA_W-1:0] fill_data_q, fill_data_d;
    logic              write_en_q, write_en_d;
    logic [ADDR_W-1:0] write_addr_q, write_addr_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;

    logic window;
    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;
    logic fill_issue;
    logic fill_ready;

    assign window     = !bus.gate_en || bus.blank;
    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign push       = bus.cpu_wr_valid && bus.cpu_wr_ready;

    assign bus.cpu_wr_ready = !reset && !fifo_full;
    assign bus.fill_ready   = fill_ready;
    assign bus.fill_busy    = (state_q == FILL);
    assign bus.fifo_level   = level_q;
    assign bus.write_enable = write_en_q;
    assign bus.write_addr   = write_addr_q;
    assign bus.write_data   = write_data_q;

    // The head entry may be popped straight from IDLE so an MCU write reaches the
    // memory port two cycles after acceptance; a pop that empties the FIFO lands in IDLE.
    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        fill_issue   = 1'b0;
        fill_ready   = 1'b0;
        fill_addr_d  = fill_addr_q;
        fill_rem_d   = fill_rem_q;
        fill_data_d  = fill_data_q;

        case (state_q)
            IDLE: begin
                fill_ready = fifo_empty;
                if (bus.fill_start && fifo_empty && (bus.fill_count != '0)) begin
                    state_d     = FILL;
                    fill_addr_d = bus.fill_base;
                    fill_rem_d  = bus.fill_count;
                    fill_data_d = bus.fill_data;
                end else if (!fifo_empty) begin
                    state_d = DRAIN;
                    pop     = window;
                end
            end
            DRAIN: begin
                pop = window && !fifo_empty;
            end
            FILL: begin
                if (window) begin
                    fill_issue  = 1'b1;
                    fill_addr_d = fill_addr_q + 1'b1;
                    fill_rem_d  = fill_rem_q - 1'b1;
                    if (fill_rem_q == {{ADDR_W{1'b0}}, 1'b1}) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q + LVL_W'(push) - LVL_W'(pop);

        if ((state_d == DRAIN) && (level_d == '0)) begin
            state_d = IDLE;
        end

        write_en_d   = pop || fill_issue;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        if (pop) begin
            write_addr_d = fifo_addr_mem[rd_ptr_q];
            write_data_d = fifo_data_mem[rd_ptr_q];
        end else if (fill_issue) begin
            write_addr_d = fill_addr_q;
            write_data_d = fill_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_mem[wr_ptr_q] <= bus.cpu_wr_addr;
            fifo_data_mem[wr_ptr_q] <= bus.cpu_wr_data;
        end
    end

    // Reset empties the FIFO and aborts any fill in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            fill_addr_q  <= '0;
            fill_rem_q   <= '0;
            fill_data_q  <= '0;
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            fill_addr_q  <= fill_addr_d;
            fill_rem_q   <= fill_rem_d;
            fill_data_q  <= fill_data_d;
            write_en_q   <= write_en_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
        end
    end
endmodule

// File: tb/tb_vram_tile_write_scheduler.sv
// Directed bench for vram_tile_write_scheduler: MCU queueing, write-window gating,
// fill wrap-around, long gated fill with a queued MCU write, ignored fills and reset abort.
module tb_vram_tile_write_scheduler;
    logic clk;
    logic reset;
    int   assertCount;
    int   failCount;
    int   cycleCnt;
    int   winViol;
    logic winPrev;
    logic blankMain;
    logic blankToggle;
    logic toggleEn;
    int   toggleCnt;

    logic [14:0] qAddr [$];
    logic [15:0] qData [$];
    int          qCycle [$];

    vram_tile_write_scheduler_if #(.ADDR_W(15), .DATA_W(16), .FIFO_DEPTH(16)) bus ();

    vram_tile_write_scheduler #(.ADDR_W(15), .DATA_W(16), .FIFO_DEPTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.blank = toggleEn ? blankToggle : blankMain;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Blank toggles every 8 cycles while enabled.
    initial begin
        blankToggle = 1'b0;
        toggleCnt   = 0;
        forever begin
            @(posedge clk);
            #1;
            if (toggleEn) begin
                toggleCnt = toggleCnt + 1;
                if (toggleCnt == 8) begin
                    toggleCnt   = 0;
                    blankToggle = ~blankToggle;
                end
            end
        end
    end

    // Logs every committed write; a write must follow a cycle whose window was open.
    initial begin
        cycleCnt = 0;
        winViol  = 0;
        winPrev  = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.write_enable === 1'b1) begin
                qAddr.push_back(bus.write_addr);
                qData.push_back(bus.write_data);
                qCycle.push_back(cycleCnt);
                if (!winPrev) winViol = winViol + 1;
            end
            winPrev  = !bus.gate_en || bus.blank;
            cycleCnt = cycleCnt + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount = assertCount + 1;
        if (actual !== expected) begin
            failCount = failCount + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic clearLog();
        qAddr.delete();
        qData.delete();
        qCycle.delete();
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pushes one MCU write, holding valid until the FIFO accepts it.
    task automatic applyStimulus(input logic [14:0] addr, input logic [15:0] data);
        logic accepted;
        accepted = 1'b0;
        bus.cpu_wr_valid = 1'b1;
        bus.cpu_wr_addr  = addr;
        bus.cpu_wr_data  = data;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            accepted = bus.cpu_wr_ready;
            @(posedge clk);
            #1;
        end
        bus.cpu_wr_valid = 1'b0;
        checkOutput("push_accept", {31'd0, accepted}, 32'd1);
    endtask

    task automatic startFill(input logic [14:0] base, input logic [15:0] count,
                             input logic [15:0] data, output logic readySeen);
        bus.fill_start = 1'b1;
        bus.fill_base  = base;
        bus.fill_count = count;
        bus.fill_data  = data;
        @(negedge clk);
        readySeen = bus.fill_ready;
        @(posedge clk);
        #1;
        bus.fill_start = 1'b0;
    endtask

    task automatic waitFillDone(input int budget);
        for (int i = 0; i < budget && bus.fill_busy; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("fill_done_in_budget", {31'd0, bus.fill_busy}, 32'd0);
    endtask

    initial begin
        logic rdy;
        int   errs;
        int   sizeAtReset;
        assertCount      = 0;
        failCount        = 0;
        reset            = 1'b1;
        toggleEn         = 1'b0;
        blankMain        = 1'b0;
        bus.gate_en      = 1'b0;
        bus.cpu_wr_valid = 1'b0;
        bus.cpu_wr_addr  = '0;
        bus.cpu_wr_data  = '0;
        bus.fill_start   = 1'b0;
        bus.fill_base    = '0;
        bus.fill_count   = '0;
        bus.fill_data    = '0;

        // Reset state
        waitCycles(3);
        @(negedge clk);
        checkOutput("rst_we", {31'd0, bus.write_enable}, 32'd0);
        checkOutput("rst_addr", {17'd0, bus.write_addr}, 32'd0);
        checkOutput("rst_data", {16'd0, bus.write_data}, 32'd0);
        checkOutput("rst_level", {27'd0, bus.fifo_level}, 32'd0);
        checkOutput("rst_busy", {31'd0, bus.fill_busy}, 32'd0);
        checkOutput("rst_ready", {31'd0, bus.cpu_wr_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        waitCycles(2);

        // Single MCU write, window always open, lands two cycles after acceptance
        $display("[TB] single write latency");
        clearLog();
        applyStimulus(15'h0001, 16'hABCD);
        @(negedge clk);
        checkOutput("t1_we_n1", {31'd0, bus.write_enable}, 32'd0);
        @(negedge clk);
        checkOutput("t1_we_n2", {31'd0, bus.write_enable}, 32'd1);
        checkOutput("t1_addr", {17'd0, bus.write_addr}, 32'h0001);
        checkOutput("t1_data", {16'd0, bus.write_data}, 32'hABCD);
        @(negedge clk);
        checkOutput("t1_we_n3", {31'd0, bus.write_enable}, 32'd0);
        waitCycles(2);

        // Window closed: 16 writes fill the FIFO, then drain in order when blank rises
        $display("[TB] gated FIFO fill and drain");
        clearLog();
        bus.gate_en = 1'b1;
        blankMain   = 1'b0;
        for (int i = 0; i < 16; i++) applyStimulus(15'h0100 + 15'(i), 16'h5000 + 16'(i));
        waitCycles(3);
        @(negedge clk);
        checkOutput("t2_level", {27'd0, bus.fifo_level}, 32'd16);
        checkOutput("t2_ready_full", {31'd0, bus.cpu_wr_ready}, 32'd0);
        checkOutput("t2_no_write", qAddr.size(), 32'd0);
        @(posedge clk);
        #1;
        blankMain = 1'b1;
        waitCycles(22);
        checkOutput("t2_count", qAddr.size(), 32'd16);
        errs = 0;
        for (int i = 0; i < 16 && i < qAddr.size(); i++) begin
            if (qAddr[i] !== 15'h0100 + 15'(i) || qData[i] !== 16'h5000 + 16'(i)) errs++;
        end
        checkOutput("t2_order", errs, 32'd0);
        if (qCycle.size() == 16) checkOutput("t2_back_to_back", qCycle[15] - qCycle[0], 32'd15);
        checkOutput("t2_level_empty", {27'd0, bus.fifo_level}, 32'd0);

        // Fill wraps past the top of the address space
        $display("[TB] fill wrap");
        clearLog();
        bus.gate_en = 1'b0;
        startFill(15'h7FFE, 16'd4, 16'h1111, rdy);
        checkOutput("t3_fill_ready", {31'd0, rdy}, 32'd1);
        @(negedge clk);
        checkOutput("t3_busy", {31'd0, bus.fill_busy}, 32'd1);
        waitCycles(8);
        checkOutput("t3_count", qAddr.size(), 32'd4);
        if (qAddr.size() == 4) begin
            checkOutput("t3_a0", {17'd0, qAddr[0]}, 32'h7FFE);
            checkOutput("t3_a1", {17'd0, qAddr[1]}, 32'h7FFF);
            checkOutput("t3_a2", {17'd0, qAddr[2]}, 32'h0000);
            checkOutput("t3_a3", {17'd0, qAddr[3]}, 32'h0001);
            checkOutput("t3_data", {16'd0, qData[2]}, 32'h1111);
        end
        checkOutput("t3_busy_end", {31'd0, bus.fill_busy}, 32'd0);

        // Ignored fill requests: FIFO non-empty, and zero count
        $display("[TB] ignored fills");
        clearLog();
        bus.gate_en = 1'b1;
        blankMain   = 1'b0;
        applyStimulus(15'h0200, 16'h4444);
        startFill(15'h0300, 16'd5, 16'h5555, rdy);
        checkOutput("t5_ready_nonempty", {31'd0, rdy}, 32'd0);
        @(negedge clk);
        checkOutput("t5_busy_nonempty", {31'd0, bus.fill_busy}, 32'd0);
        @(posedge clk);
        #1;
        blankMain = 1'b1;
        waitCycles(10);
        checkOutput("t5_one_write", qAddr.size(), 32'd1);
        if (qAddr.size() >= 1) checkOutput("t5_mcu_addr", {17'd0, qAddr[0]}, 32'h0200);
        clearLog();
        bus.gate_en = 1'b0;
        startFill(15'h0400, 16'd0, 16'h6666, rdy);
        @(negedge clk);
        checkOutput("t5_busy_zero", {31'd0, bus.fill_busy}, 32'd0);
        waitCycles(10);
        checkOutput("t5_no_write", qAddr.size(), 32'd0);

        // Full-memory fill with blank toggling; MCU write queued mid-fill commits last
        $display("[TB] full fill with toggling window");
        clearLog();
        winViol     = 0;
        bus.gate_en = 1'b1;
        toggleCnt   = 0;
        blankToggle = 1'b0;
        toggleEn    = 1'b1;
        startFill(15'h0100, 16'h8000, 16'h2222, rdy);
        checkOutput("t4_fill_ready", {31'd0, rdy}, 32'd1);
        waitCycles(1000);
        applyStimulus(15'h0010, 16'h9999);
        waitFillDone(80000);
        waitCycles(40);
        toggleEn  = 1'b0;
        blankMain = 1'b1;
        waitCycles(2);
        checkOutput("t4_total", qAddr.size(), 32'd32769);
        errs = 0;
        for (int i = 0; i < 32768 && i < qAddr.size(); i++) begin
            if (qAddr[i] !== 15'(32'h0100 + i) || qData[i] !== 16'h2222) errs++;
        end
        checkOutput("t4_fill_seq", errs, 32'd0);
        if (qAddr.size() == 32769) begin
            checkOutput("t4_last_addr", {17'd0, qAddr[32768]}, 32'h0010);
            checkOutput("t4_last_data", {16'd0, qData[32768]}, 32'h9999);
        end
        checkOutput("t4_window_viol", winViol, 32'd0);

        // Reset in the middle of a fill with one MCU write queued behind it
        $display("[TB] reset mid-fill");
        clearLog();
        bus.gate_en = 1'b0;
        startFill(15'h0000, 16'd100, 16'h3333, rdy);
        applyStimulus(15'h0050, 16'h7777);
        for (int i = 0; i < 200 && qAddr.size() < 10; i++) @(negedge clk);
        checkOutput("t6_reached_10", {31'd0, qAddr.size() >= 10}, 32'd1);
        checkOutput("t6_level_pre", {27'd0, bus.fifo_level}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t6_ready_rst", {31'd0, bus.cpu_wr_ready}, 32'd0);
        @(negedge clk);
        checkOutput("t6_we", {31'd0, bus.write_enable}, 32'd0);
        checkOutput("t6_level", {27'd0, bus.fifo_level}, 32'd0);
        checkOutput("t6_busy", {31'd0, bus.fill_busy}, 32'd0);
        sizeAtReset = qAddr.size();
        @(posedge clk);
        #1;
        reset = 1'b0;
        waitCycles(20);
        checkOutput("t6_no_more_writes", qAddr.size(), sizeAtReset);
        checkOutput("t6_busy_after", {31'd0, bus.fill_busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
